conv_filter_scheduler: RTL and testbench
========================================

Name: conv_filter_scheduler

Overview:
- Sequences the 3x3 convolution datapath per window: steps the kernel-buffer select through every filter, issues DSP input strobes, advances the window buffer and signals job completion.
- Sits between the window buffer, kernel buffer, ConvDSP and the output stream FIFO.
- Applies credit-based backpressure so the DSP never produces results the output FIFO cannot hold.

Parameters:
- MAX_FILTERS, 512, maximum filter count; sel width is $clog2(MAX_FILTERS).
- OUT_FIFO_DEPTH, 16, output FIFO capacity; initial credit count.

Ports:
- i_aclk  in  1  clock; all logic on rising edge.
- i_areset  in  1  asynchronous, active-high reset.
- i_load_param  in  1  latch i_filters (honoured in IDLE only).
- i_filters  in  $clog2(MAX_FILTERS)+1  filters per window.
- i_start  in  1  begin job (honoured in IDLE only).
- i_window_valid  in  1  window buffer holds a complete window.
- i_last_window  in  1  current window is the final one; sampled with i_window_valid.
- o_window_advance  out  1  one-cycle pulse: window consumed, advance window buffer.
- o_sel_valid  out  1  kernel read strobe.
- o_sel  out  $clog2(MAX_FILTERS)  kernel index.
- o_dsp_in_valid  out  1  DSP input strobe.
- o_dsp_last_window  out  1  qualifies o_dsp_in_valid for the last window's final filter.
- i_dsp_out_valid  in  1  DSP produced one result.
- i_out_pop  in  1  output FIFO released one entry (downstream handshake).
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous: state=IDLE, filters_q=0, sel=0, credits=OUT_FIFO_DEPTH, outstanding=0. All outputs 0.
- IDLE:
  - i_load_param latches filters_q.
  - i_start with filters_q!=0 goes to WAIT_WIN. i_start with filters_q==0 is ignored.
  - If i_start and i_load_param arrive in the same cycle, the load takes effect first.
- WAIT_WIN: on i_window_valid, latch last_q=i_last_window, set sel=0, go to ISSUE.
- ISSUE, each cycle with credits>0:
  - o_sel_valid=1, o_sel=sel; sel increments.
  - With credits==0, o_sel_valid=0 and sel holds.
  - When the issued sel equals filters_q-1:
    - o_window_advance pulses in the same cycle.
    - Next state is DRAIN if last_q, otherwise WAIT_WIN.
- Latency:
  - o_dsp_in_valid is o_sel_valid registered once, to match the kernel buffer's registered read.
  - o_dsp_last_window is registered the same way; it is 1 only for the final sel of the last_q window.
- Credits:
  - Decrement on o_sel_valid; increment on i_out_pop.
  - Both in the same cycle: no change.
  - Never exceeds OUT_FIFO_DEPTH; a pop at full credit is ignored.
- outstanding:
  - Increments on o_dsp_in_valid; decrements on i_dsp_out_valid.
  - Both in the same cycle: no change.
  - A decrement at 0 saturates at 0.
- DRAIN: when outstanding==0 and o_dsp_in_valid==0, go to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- Counter widths:
  - credits: $clog2(OUT_FIFO_DEPTH+1).
  - outstanding: same width; it is bounded by credits.
- Mid-job reset: everything returns to reset values immediately. In-flight DSP results are discarded by the system reset.
- i_window_valid outside WAIT_WIN is ignored.

Optional Feature:
- Macro CONV_SCHED_PERF_EN.
- Defined:
  - Adds output o_stall_cycles [31:0]. It counts ISSUE cycles blocked by credits==0, saturating at 32'hFFFF_FFFF.
  - Cleared on i_start accepted and on reset.
- Not defined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package conv_pkg:
  - State enum: IDLE, WAIT_WIN, ISSUE, DRAIN, DONE.
  - Width localparams: SEL_W, CREDIT_W.
- Sub-module conv_credit_counter:
  - Generic up/down counter with init value, saturation and simultaneous inc/dec.
  - Instantiated twice: credits and outstanding.

Test Plan:
- Basic job:
  - Stimulus: filters=3, OUT_FIFO_DEPTH=16, two windows (second flagged last), i_out_pop echoes i_dsp_out_valid, DSP latency 4.
  - Response: o_sel sequence 0,1,2,0,1,2; two o_window_advance pulses; o_dsp_last_window exactly once; o_done one cycle after the 6th result.
- Backpressure:
  - Stimulus: OUT_FIFO_DEPTH=2, filters=5, no i_out_pop until cycle 20.
  - Response: exactly 2 o_sel_valid, then stall; issue resumes one per pop; o_stall_cycles counts stalled cycles when CONV_SCHED_PERF_EN is defined.
- Simultaneous events:
  - Stimulus: i_out_pop concurrent with o_sel_valid at credits=1.
  - Response: credits stays 1 and issue continues without a bubble.
- Zero filters:
  - Stimulus: load filters=0, then i_start.
  - Response: o_busy stays 0; no strobes.
- Mid-job reset:
  - Stimulus: assert i_areset during ISSUE at sel=2.
  - Response: outputs 0 immediately, credits=OUT_FIFO_DEPTH. A fresh job with filters=1 completes with a single sel=0.
- Ignored inputs:
  - Stimulus: i_load_param with filters=7 and i_start while o_busy=1.
  - Response: both ignored; the current job finishes with its original filter count.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - scheduler state encoding, default sizing and width helpers
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WIN,
    ISSUE,
    DRAIN,
    DONE
  } sched_state_e;

  function automatic int sel_width(input int max_filters);
    return (max_filters > 1) ? $clog2(max_filters) : 1;
  endfunction

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_MAX_FILTERS    = 512;
  localparam int DEF_OUT_FIFO_DEPTH = 16;
  localparam int SEL_W              = sel_width(DEF_MAX_FILTERS);
  localparam int CREDIT_W           = credit_width(DEF_OUT_FIFO_DEPTH);

endpackage

// File: rtl/conv_credit_counter.sv
// rtl/conv_credit_counter.sv - saturating up/down counter with reset value
// Simultaneous inc and dec cancel; inc at MAX and dec at zero are dropped.
module conv_credit_counter #(
  parameter int W    = 5,
  parameter int INIT = 16,
  parameter int MAX  = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] INIT_V = W'(INIT);
  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] ONE_V  = W'(1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && count_q != MAX_V) begin
      count_d = count_q + ONE_V;
    end else if (dec_i && !inc_i && count_q != '0) begin
      count_d = count_q - ONE_V;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= INIT_V;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/conv_filter_scheduler.sv
// rtl/conv_filter_scheduler.sv - per-window filter sequencer with output-FIFO credit backpressure
// Define CONV_SCHED_PERF_EN to add the o_stall_cycles credit-stall counter.
module conv_filter_scheduler
  import conv_pkg::*;
#(
  parameter int MAX_FILTERS    = DEF_MAX_FILTERS,
  parameter int OUT_FIFO_DEPTH = DEF_OUT_FIFO_DEPTH,
  localparam int SB = sel_width(MAX_FILTERS),
  localparam int CB = credit_width(OUT_FIFO_DEPTH)
) (
  input  logic          i_aclk,
  input  logic          i_areset,
  input  logic          i_load_param,
  input  logic [SB:0]   i_filters,
  input  logic          i_start,
  input  logic          i_window_valid,
  input  logic          i_last_window,
  output logic          o_window_advance,
  output logic          o_sel_valid,
  output logic [SB-1:0] o_sel,
  output logic          o_dsp_in_valid,
  output logic          o_dsp_last_window,
  input  logic          i_dsp_out_valid,
  input  logic          i_out_pop,
  output logic          o_busy,
`ifdef CONV_SCHED_PERF_EN
  output logic [31:0]   o_stall_cycles,
`endif
  output logic          o_done
);

  localparam logic [SB:0]   ONE_F = (SB + 1)'(1);
  localparam logic [SB-1:0] ONE_S = SB'(1);

  sched_state_e  state_q, state_d;
  logic [SB:0]   filters_q, filters_d;
  logic [SB-1:0] sel_q, sel_d;
  logic          last_q, last_d;
  logic          dsp_valid_q, dsp_last_q;
  logic [CB-1:0] credits, outstanding;
  logic          issue, final_sel, done;

  always_comb begin
    state_d   = state_q;
    filters_d = filters_q;
    sel_d     = sel_q;
    last_d    = last_q;
    issue     = 1'b0;
    final_sel = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        // A same-cycle load is visible to the start check.
        if (i_load_param) filters_d = i_filters;
        if (i_start && filters_d != '0) state_d = WAIT_WIN;
      end
      WAIT_WIN: begin
        if (i_window_valid) begin
          last_d  = i_last_window;
          sel_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (credits != '0) begin
          issue = 1'b1;
          sel_d = sel_q + ONE_S;
          if ({1'b0, sel_q} == filters_q - ONE_F) begin
            final_sel = 1'b1;
            state_d   = last_q ? DRAIN : WAIT_WIN;
          end
        end
      end
      DRAIN: begin
        if (outstanding == '0 && !dsp_valid_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q     <= IDLE;
      filters_q   <= '0;
      sel_q       <= '0;
      last_q      <= 1'b0;
      dsp_valid_q <= 1'b0;
      dsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      filters_q   <= filters_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      dsp_valid_q <= issue;
      dsp_last_q  <= final_sel && last_q;
    end
  end

  // Credits mirror free output-FIFO slots; outstanding tracks results still inside the DSP.
  conv_credit_counter #(.W(CB), .INIT(OUT_FIFO_DEPTH), .MAX(OUT_FIFO_DEPTH)) u_credits (
    .clk_i   (i_aclk),
    .rst_i   (i_areset),
    .inc_i   (i_out_pop),
    .dec_i   (issue),
    .count_o (credits)
  );

  conv_credit_counter #(.W(CB), .INIT(0), .MAX(OUT_FIFO_DEPTH)) u_outstanding (
    .clk_i   (i_aclk),
    .rst_i   (i_areset),
    .inc_i   (dsp_valid_q),
    .dec_i   (i_dsp_out_valid),
    .count_o (outstanding)
  );

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] stall_q;
  logic        start_ok;

  assign start_ok = (state_q == IDLE) && i_start &&
                    ((i_load_param ? i_filters : filters_q) != '0);

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (state_q == ISSUE && credits == '0 && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign o_stall_cycles = stall_q;
`endif

  assign o_sel_valid       = issue;
  assign o_sel             = sel_q;
  assign o_window_advance  = final_sel;
  assign o_dsp_in_valid    = dsp_valid_q;
  assign o_dsp_last_window = dsp_last_q;
  assign o_busy            = (state_q != IDLE);
  assign o_done            = done;

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// tb/tb_conv_filter_scheduler.sv - directed scoreboard bench for conv_filter_scheduler
// Covers the optional o_stall_cycles port when CONV_SCHED_PERF_EN is defined.
module tb_conv_filter_scheduler;
  import conv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, load, start, win_valid, win_last, echo_en;
  logic [SEL_W:0]   filters;
  logic             dsp_out_valid, out_pop;
  logic             o_window_advance, o_sel_valid, o_dsp_in_valid, o_dsp_last_window, o_busy, o_done;
  logic [SEL_W-1:0] o_sel;

  logic             bp_load, bp_start, bp_win_valid, bp_win_last, bp_pop;
  logic [SEL_W:0]   bp_filters;
  logic             bp_dsp_out_valid;
  logic             bp_adv, bp_sel_valid, bp_dsp_valid, bp_dsp_last, bp_busy, bp_done;
  logic [SEL_W-1:0] bp_sel_o;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]      stall_a, stall_b;
`endif

  conv_filter_scheduler u_dut (
    .i_aclk(clk), .i_areset(rst), .i_load_param(load), .i_filters(filters), .i_start(start),
    .i_window_valid(win_valid), .i_last_window(win_last), .o_window_advance(o_window_advance),
    .o_sel_valid(o_sel_valid), .o_sel(o_sel), .o_dsp_in_valid(o_dsp_in_valid),
    .o_dsp_last_window(o_dsp_last_window), .i_dsp_out_valid(dsp_out_valid), .i_out_pop(out_pop),
    .o_busy(o_busy),
`ifdef CONV_SCHED_PERF_EN
    .o_stall_cycles(stall_a),
`endif
    .o_done(o_done)
  );

  conv_filter_scheduler #(.OUT_FIFO_DEPTH(2)) u_bp (
    .i_aclk(clk), .i_areset(rst), .i_load_param(bp_load), .i_filters(bp_filters), .i_start(bp_start),
    .i_window_valid(bp_win_valid), .i_last_window(bp_win_last), .o_window_advance(bp_adv),
    .o_sel_valid(bp_sel_valid), .o_sel(bp_sel_o), .o_dsp_in_valid(bp_dsp_valid),
    .o_dsp_last_window(bp_dsp_last), .i_dsp_out_valid(bp_dsp_out_valid), .i_out_pop(bp_pop),
    .o_busy(bp_busy),
`ifdef CONV_SCHED_PERF_EN
    .o_stall_cycles(stall_b),
`endif
    .o_done(bp_done)
  );

  // DSP models (4-cycle pipes) and output monitors, all sampled on the falling edge
  logic [3:0]       pipe = '0, bp_pipe = '0;
  int               cyc = 0, obs_n = 0, adv_n = 0, lastw_n = 0, done_n = 0;
  int               done_cyc = 0, last_res_cyc = 0;
  logic [SEL_W-1:0] obs_sel [256];
  int               bp_n = 0, bp_stall_obs = 0, bp_done_n = 0;
  int               bp_sel [16], bp_sel_cyc [16], bp_cred [16];
  logic             bp_issuing = 1'b0;

  assign dsp_out_valid    = pipe[3];
  assign out_pop          = echo_en & pipe[3];
  assign bp_dsp_out_valid = bp_pipe[3];

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    pipe    <= {pipe[2:0], o_dsp_in_valid};
    bp_pipe <= {bp_pipe[2:0], bp_dsp_valid};
    if (pipe[2]) last_res_cyc <= cyc;
    if (o_sel_valid && obs_n < 256) begin
      obs_sel[obs_n] <= o_sel;
      obs_n          <= obs_n + 1;
    end
    if (o_window_advance)  adv_n   <= adv_n + 1;
    if (o_dsp_last_window) lastw_n <= lastw_n + 1;
    if (o_done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (bp_sel_valid && bp_n < 16) begin
      bp_sel[bp_n]     <= int'(bp_sel_o);
      bp_sel_cyc[bp_n] <= cyc;
      bp_cred[bp_n]    <= int'(u_bp.credits);
      bp_n             <= bp_n + 1;
    end
    if (bp_sel_valid) bp_issuing <= !bp_adv;
    else if (bp_issuing) bp_stall_obs <= bp_stall_obs + 1;
    if (bp_done) bp_done_n <= bp_done_n + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int obs_rd = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_sel[%0d]", tag, obs_rd),
          (obs_rd < obs_n) ? 64'(obs_sel[obs_rd]) : 64'hDEAD, 64'(e));
      obs_rd++;
    end
    chk({tag, "_strobe_count"}, obs_n, obs_rd);
  endtask

  task automatic wait_adv(input string tag);
    int k = 0;
    while (!o_window_advance && k < 100) begin tick(1); k++; end
    chk(tag, 64'(k < 100), 1);
  endtask

  task automatic wait_done(input string tag, input int base);
    int k = 0;
    while (done_n == base && k < 300) begin tick(1); k++; end
    chk({tag, "_done_count"}, done_n - base, 1);
  endtask

  int base, adv0, lw0, k;

  initial begin
    rst = 1'b1; load = 0; filters = '0; start = 0; win_valid = 0; win_last = 0; echo_en = 0;
    bp_load = 0; bp_filters = '0; bp_start = 0; bp_win_valid = 0; bp_win_last = 0; bp_pop = 0;
    tick(2);
    chk("reset_outputs", {o_busy, o_sel_valid, o_sel, o_dsp_in_valid, o_dsp_last_window,
                          o_window_advance, o_done}, 0);
    chk("reset_credits", u_dut.credits, DEF_OUT_FIFO_DEPTH);
    rst = 1'b0;
    tick(2);
    chk("idle_outputs", {o_busy, o_sel_valid, o_dsp_in_valid, o_window_advance, o_done}, 0);

    // zero filters: load 0 with start, then start alone
    load = 1; filters = '0; start = 1; tick(1); load = 0; start = 0;
    tick(1); start = 1; tick(1); start = 0;
    chk("zero_busy_early", o_busy, 0);
    tick(3);
    chk("zero_busy_late", o_busy, 0);
    chk("zero_strobes", obs_n, 0);

    // basic job: 3 filters, two windows, pops echo DSP results
    echo_en = 1; base = done_n; adv0 = adv_n; lw0 = lastw_n; obs_rd = obs_n;
    for (int w = 0; w < 2; w++) for (int s = 0; s < 3; s++) exp_q.push_back(s);
    load = 1; filters = 3; start = 1; win_valid = 1; win_last = 0;
    tick(1); load = 0; start = 0;
    wait_adv("basic_adv1_seen");
    win_last = 1;
    tick(1);
    wait_adv("basic_adv2_seen");
    tick(1); win_valid = 0;
    wait_done("basic", base);
    tick(2);
    chk("basic_adv_pulses", adv_n - adv0, 2);
    chk("basic_last_window_once", lastw_n - lw0, 1);
    chk("basic_done_after_result", done_cyc - last_res_cyc, 2);
    chk("basic_done_single", done_n - base, 1);
    chk("basic_idle_after", o_busy, 0);
    chk("basic_credits_restored", u_dut.credits, DEF_OUT_FIFO_DEPTH);
`ifdef CONV_SCHED_PERF_EN
    chk("basic_no_stall", stall_a, 0);
`endif
    drain("basic");

    // load/start while busy must not disturb the running 3-filter job
    base = done_n; adv0 = adv_n;
    for (int s = 0; s < 3; s++) exp_q.push_back(s);
    start = 1; win_valid = 1; win_last = 1; tick(1); start = 0;
    tick(2);
    chk("ignored_busy_at_load", o_busy, 1);
    load = 1; filters = 7; start = 1; tick(1); load = 0; start = 0; filters = 3;
    wait_done("ignored", base);
    tick(3); win_valid = 0;
    chk("ignored_adv_pulses", adv_n - adv0, 1);
    chk("ignored_no_restart", o_busy, 0);
    drain("ignored");

    // reset in the middle of issuing, at sel=2
    start = 1; win_valid = 1; win_last = 0; tick(1); start = 0;
    k = 0;
    while (!(o_sel_valid && o_sel == 2) && k < 50) begin tick(1); k++; end
    chk("midrst_reached_sel2", 64'(k < 50), 1);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {o_busy, o_sel_valid, o_sel, o_dsp_in_valid, o_dsp_last_window,
                           o_window_advance, o_done}, 0);
    chk("midrst_credits", u_dut.credits, DEF_OUT_FIFO_DEPTH);
    @(negedge clk); rst = 1'b0; win_valid = 0;
    tick(10);
    obs_rd = obs_n; base = done_n; lw0 = lastw_n;
    chk("midrst_stale_credits", u_dut.credits, DEF_OUT_FIFO_DEPTH);
    exp_q.push_back(0);
    load = 1; filters = 1; start = 1; win_valid = 1; win_last = 1;
    tick(1); load = 0; start = 0;
    wait_done("fresh", base);
    tick(2); win_valid = 0;
    chk("fresh_last_window_once", lastw_n - lw0, 1);
    drain("fresh");

    // backpressure on the 2-deep instance, no pops until cycle 20
    bp_load = 1; bp_filters = 5; bp_start = 1; bp_win_valid = 1; bp_win_last = 1;
    tick(1); bp_load = 0; bp_start = 0;
    tick(19);
    chk("bp_two_issued", bp_n, 2);
    chk("bp_credits_empty", u_bp.credits, 0);
    bp_pop = 1; tick(1); bp_pop = 0;
    tick(3);
    chk("bp_one_per_pop", bp_n, 3);
    bp_pop = 1; tick(6); bp_pop = 0;
    tick(2);
    chk("bp_all_issued", bp_n, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("bp_sel[%0d]", i), bp_sel[i], i);
    chk("bp_no_bubble", bp_sel_cyc[4] - bp_sel_cyc[3], 1);
    chk("bp_credit_held", bp_cred[4], 1);
    chk("bp_credit_saturate", u_bp.credits, 2);
    k = 0;
    while (bp_done_n == 0 && k < 100) begin tick(1); k++; end
    chk("bp_done_count", bp_done_n, 1);
    bp_win_valid = 0;
`ifdef CONV_SCHED_PERF_EN
    chk("bp_stall_cycles", stall_b, bp_stall_obs);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
